// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer and its bit counter.
// Holds the state encoding, default word width and counter sizing.
package piso_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // A one-bit counter still needs a real bit when WIDTH is 2.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for serial word framing.
// Ports: clk, rst (async high), clear, inc, last (cnt == WIDTH-1).
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic last
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == LAST_CNT);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with valid/ready load handshake.
// Ports: clk, rst, data_in, load_valid, load_ready, serial_out, frame, done.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             frame,
    output logic             done
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [WIDTH-1:0] shifted;
    logic             out_bit;
    logic             last;
    logic             accept;
    logic             cnt_clear;
    logic             cnt_inc;

    piso_bit_counter #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clear(cnt_clear),
        .inc  (cnt_inc),
        .last (last)
    );

    // Vacated bit always fills with zero.
    assign shifted = LSB_FIRST ? {1'b0, shreg[WIDTH-1:1]}
                               : {shreg[WIDTH-2:0], 1'b0};
    assign out_bit = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];

    // Ready depends on registered state only, never on load_valid.
    assign load_ready = (state == ST_IDLE)
                      | ((state == ST_SHIFT) & last);
    assign accept     = load_valid & load_ready;

    assign frame      = (state == ST_SHIFT);
    assign serial_out = frame & out_bit;
    assign done       = frame & last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        if (accept) begin
            // Accepting in the last-bit cycle chains words with no gap.
            shreg_nxt = data_in;
            cnt_clear = 1'b1;
            state_nxt = ST_SHIFT;
        end else if (state == ST_SHIFT) begin
            if (last) begin
                state_nxt = ST_IDLE;
            end else begin
                shreg_nxt = shifted;
                cnt_inc   = 1'b1;
            end
        end
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out transmitter that feeds the serial input of the team's SISO shift-register chain. It accepts a WIDTH-bit word through a valid/ready load handshake and presents it one bit per clock on `serial_out`, qualified by `frame`. Back-to-back words stream with no idle gap.

## Interface
Parameters:
- `WIDTH`, 4: word width in bits; legal range 2 to 32.
- `LSB_FIRST`, 0: 0 shifts MSB first; 1 shifts LSB first.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `data_in`  in  WIDTH  parallel word to transmit.
- `load_valid`  in  1  `data_in` is valid this cycle.
- `load_ready`  out  1  the block can accept a word this cycle.
- `serial_out`  out  1  current serial bit; 0 when `frame` = 0.
- `frame`  out  1  high while `serial_out` carries a valid bit.
- `done`  out  1  high during the last bit of each word.

One clock; reset is asynchronous and active-high.

## Operation
- The block has two states:
  - IDLE: no word is loaded.
  - SHIFT: a word is being sent.
- Internal registers:
  - `shreg[WIDTH-1:0]`.
  - bit counter `cnt`, sized $clog2(WIDTH).
- `load_ready` = (state == IDLE) | (state == SHIFT & cnt == WIDTH-1).
- Accept: `load_valid & load_ready` at a rising edge. On accept:
  - `shreg` <= `data_in`.
  - `cnt` <= 0.
  - state <= SHIFT.
- In SHIFT without an accept, each edge:
  - If `cnt` < WIDTH-1: shift `shreg` toward the output end and increment `cnt`.
  - If `cnt` == WIDTH-1: state <= IDLE.
- Output end of `shreg`:
  - `LSB_FIRST` = 0: the output bit is `shreg[WIDTH-1]` and the register shifts left.
  - `LSB_FIRST` = 1: the output bit is `shreg[0]` and the register shifts right.
  - The vacated bit is filled with 0.
- Outputs:
  - `frame` = (state == SHIFT).
  - `serial_out` = `frame` & output bit.
  - `done` = `frame` & (`cnt` == WIDTH-1).
- `load_valid` while `load_ready` = 0 is ignored. The word is not captured, and the sender must hold it until it sees `load_ready` = 1.
- `data_in` is sampled only on an accept edge.

## Timing
- Reset values, applied immediately on `rst` assertion:
  - state IDLE, `shreg` = 0, `cnt` = 0.
  - `frame` = 0, `serial_out` = 0, `done` = 0, `load_ready` = 1.
- Latency: for a word accepted at edge k, bit i (0-based, in shift order) appears in the cycle after edge k+i. `frame` is high for exactly WIDTH cycles.
- `done` is high for one cycle per word, coinciding with the last bit.
- Back-to-back: an accept during the last-bit cycle starts the next word in the next cycle, so `frame` stays high continuously.
- Reset mid-word:
  - `frame` and `serial_out` drop to 0 at once.
  - No `done` is produced for the aborted word.
  - After `rst` deasserts, the first edge may accept a new word.
- `load_ready` is combinational from registered state only. It never depends on `load_valid`, so there is no combinational loop with the sender.

## Structure
- Shared package `piso_pkg` holds:
  - the state encoding constants `ST_IDLE` = 1'b0 and `ST_SHIFT` = 1'b1;
  - the default `WIDTH` value;
  - the counter-width function.
- One sub-module is natural: `piso_bit_counter`. It contains the `cnt` register with clear and increment inputs and a `last` output (`cnt` == WIDTH-1), and is reusable by the matching SIPO receiver.
- Expected size: 120–200 lines of RTL total.

## Test plan
- Reset: assert `rst` with no clock edges. Required: `frame` = 0, `serial_out` = 0, `done` = 0, `load_ready` = 1.
- Single word: WIDTH = 4, `LSB_FIRST` = 0, load 4'b1011. Required:
  - `serial_out` = 1, 0, 1, 1 over the next 4 cycles.
  - `frame` high for those 4 cycles.
  - `done` high in the 4th cycle only.
  - `load_ready` low in cycles 1–3.
- Back-to-back: load 4'b1011, then hold `load_valid` with 4'b0110. Required:
  - `frame` high for 8 contiguous cycles.
  - `serial_out` = 1,0,1,1,0,1,1,0.
  - `done` high in cycles 4 and 8.
- Ignored load: during cycle 2 of word 4'b1011, present 4'b0000 with `load_valid` for one cycle only. Required: the stream stays 1,0,1,1, then `frame` = 0 and the block returns to IDLE.
- Reset mid-word: assert `rst` during cycle 2 of 4'b1111. Required:
  - `frame` = 0 and `serial_out` = 0 immediately, with no `done`.
  - After release, loading 4'b0001 produces 0,0,0,1.
- LSB_FIRST: with `LSB_FIRST` = 1, load 4'b1011. Required: `serial_out` = 1,1,0,1 and `done` in the 4th cycle.
